multicycle_control_fsm: RTL and testbench

- Main controller for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and writeback across multiple clocks.
- Drives the datapath register enables (PC, IR, register file, memory write) and the mux selects for the operand, address and PC-source muxes.
- Stalls on a memory ready handshake and decodes the ALU operation from op/funct.

---
 rtl/mips_ctrl_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_control_fsm.sv | 88 ++++++++
 tb/tb_multicycle_control_fsm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and encodings for the multicycle MIPS controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, ALU_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP
  } state_t;
  typedef enum logic [1:0] {ADD, SUB, FUNCT} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_SLT = 3'b111;
  localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps aluop/funct to the ALU control code and flags unsupported functs
//   aluop         in  ADD/SUB/FUNCT request from the controller
//   funct         in  instruction[5:0]
//   alu_control   out ALU operation code
//   funct_illegal out funct not supported (only meaningful when aluop is FUNCT)
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  aluop_t                aluop,
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  funct_illegal
);
  logic [2:0] code;
  always_comb begin
    code = AC_ADD;
    funct_illegal = 1'b0;
    if (aluop == SUB) code = AC_SUB;
    else if (aluop == FUNCT)
      case (funct)
        F_ADD:   code = AC_ADD;
        F_SUB:   code = AC_SUB;
        F_AND:   code = AC_AND;
        F_OR:    code = AC_OR;
        F_SLT:   code = AC_SLT;
        default: funct_illegal = 1'b1;
      endcase
  end
  assign alu_control = ALU_CTRL_W'(code);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main controller sequencing the multicycle MIPS datapath
//   clk, reset     rising-edge clock, synchronous active-high reset
//   op, funct      instruction fields from IR; zero is the ALU zero flag
//   mem_ready      memory completes its access this cycle
//   enables        mem_read, mem_write, ir_write, pc_en, reg_write
//   mux selects    i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src
//   alu_control    ALU operation; illegal_op / mem_timeout are one-cycle pulses
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 3,
  parameter int STALL_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_op,
  output logic                  mem_timeout
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  state_t state, next;
  aluop_t aluop;
  logic [CW-1:0] stall_cnt;
  logic stall, funct_illegal, op_illegal;
  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_dec (
    .aluop(aluop), .funct(funct), .alu_control(alu_control), .funct_illegal(funct_illegal)
  );
  assign stall = (state inside {FETCH, MEMRD, MEMWR}) & ~mem_ready;
  assign op_illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
  assign aluop = state == BRANCH ? SUB : state == RTYPE_EX ? FUNCT : ADD;
  // stall counter saturates at the limit so the timeout pulse fires once per stall
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      stall_cnt <= '0;
    end else begin
      state <= next;
      stall_cnt <= !stall ? '0 : stall_cnt == CW'(STALL_LIMIT) ? stall_cnt : stall_cnt + CW'(1);
    end
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = mem_ready ? DECODE : FETCH;
      DECODE:   next = (op == OP_LW || op == OP_SW) ? MEMADR :
                       op == OP_RTYPE ? RTYPE_EX :
                       op == OP_BEQ   ? BRANCH :
                       op == OP_ADDI  ? ADDI_EX :
                       op == OP_J     ? JUMP : FETCH;
      MEMADR:   next = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:    next = mem_ready ? MEMWB : MEMRD;
      MEMWR:    next = mem_ready ? FETCH : MEMWR;
      RTYPE_EX: next = funct_illegal ? FETCH : ALU_WB;
      ADDI_EX:  next = ADDI_WB;
      default:  next = FETCH;
    endcase
  end
  always_comb begin
    mem_read    = ~reset & (state == FETCH | state == MEMRD);
    mem_write   = ~reset & state == MEMWR;
    ir_write    = ~reset & state == FETCH & mem_ready;
    pc_en       = ~reset & (state == FETCH & mem_ready | state == JUMP | state == BRANCH & zero);
    reg_write   = ~reset & (state inside {MEMWB, ALU_WB, ADDI_WB});
    i_or_d      = state == MEMRD | state == MEMWR;
    reg_dst     = state == ALU_WB;
    mem_to_reg  = state == MEMWB;
    alu_src_a   = state inside {MEMADR, RTYPE_EX, BRANCH, ADDI_EX};
    alu_src_b   = state == FETCH ? SRCB_4 : state == DECODE ? SRCB_IMM_SH :
                  (state inside {MEMADR, ADDI_EX}) ? SRCB_IMM : SRCB_B;
    pc_src      = state == BRANCH ? PC_ALUOUT : state == JUMP ? PC_JUMP : PC_ALU;
    illegal_op  = ~reset & (state == DECODE & op_illegal | state == RTYPE_EX & funct_illegal);
    mem_timeout = ~reset & stall & stall_cnt == CW'(STALL_LIMIT - 1);
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: vector-table and scoreboard bench for the multicycle controller
module tb_multicycle_control_fsm;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [17:0] act;
  int errors = 0, checks = 0;
  multicycle_control_fsm #(.ALU_CTRL_W(3), .STALL_LIMIT(2)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  assign act = {mem_read, mem_write, i_or_d, ir_write, pc_en, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, mem_timeout};
  typedef struct {
    logic rst; logic [5:0] op, funct; logic zero, rdy;
    logic [17:0] exp, mask; string name;
  } vec_t;
  typedef struct { logic [17:0] exp, mask; string name; } sb_t;
  vec_t vecs[$];
  sb_t sb[$];
  logic [17:0] all_m, en_m, ma, fet1, fet0, fet0t, dec, deci, madr, mrd, mwb, mwr, mwrt, awb, awbi, jmp, rti;
  logic [5:0] fs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] cs[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  function automatic logic [17:0] ov(input logic mr, mw, iod, irw, pce, rw, rd, m2r, sa,
                                     input logic [1:0] sb_, ps, input logic [2:0] alu,
                                     input logic ill, to);
    return {mr, mw, iod, irw, pce, rw, rd, m2r, sa, sb_, ps, alu, ill, to};
  endfunction
  task automatic add(input logic r, input logic [5:0] o, f, input logic z, rd,
                     input logic [17:0] e, m, input string n);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.zero = z; v.rdy = rd; v.exp = e; v.mask = m; v.name = n;
    vecs.push_back(v);
  endtask
  task automatic check(input logic [17:0] got, input sb_t s);
    checks++;
    if ((got & s.mask) !== (s.exp & s.mask)) begin
      errors++;
      $display("FAIL %s: got=%b want=%b mask=%b", s.name, got, s.exp, s.mask);
    end
  endtask
  task automatic lat(input logic [5:0] o, input int nstall, input int want, input string n);
    int c = 0;
    bit hit = 0;
    reset = 1'b1; mem_ready = 1'b1; op = o; funct = 6'b100000;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 1; k <= 12 && !hit; k++) begin
      mem_ready = !(o == LW && k >= 4 && k < 4 + nstall);
      @(negedge clk);
      if ((o == J && pc_en && pc_src == 2'b10) || (o == LW && reg_write && mem_to_reg)) begin
        hit = 1; c = k;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit || c != want) begin
      errors++;
      $display("FAIL %s: latency got=%0d want=%0d", n, c, want);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    all_m = '1;
    en_m  = ov(1, 1, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 1);
    ma    = ~ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b111, 0, 0);
    fet1  = ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    fet0  = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    fet0t = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 1);
    dec   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0);
    deci  = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1, 0);
    madr  = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
    mrd   = ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    mwb   = ov(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    mwr   = ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    mwrt  = ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
    awb   = ov(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    awbi  = ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    jmp   = ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0, 0);
    rti   = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 1, 0);
    add(1, LW, 0, 0, 1, '0, en_m, "reset_a");
    add(1, LW, 0, 0, 1, '0, en_m, "reset_b");
    add(0, LW, 0, 0, 1, fet1, all_m, "lw_fetch");
    add(0, LW, 0, 0, 1, dec, all_m, "lw_decode");
    add(0, LW, 0, 0, 1, madr, all_m, "lw_memadr");
    add(0, LW, 0, 0, 1, mrd, ma, "lw_memrd");
    add(0, LW, 0, 0, 1, mwb, ma, "lw_memwb");
    add(0, LW, 0, 0, 1, fet1, all_m, "rl_fetch");
    add(0, LW, 0, 0, 1, dec, all_m, "rl_decode");
    add(0, LW, 0, 0, 1, madr, all_m, "rl_memadr");
    add(0, LW, 0, 0, 0, mrd, ma, "rl_memrd_stall");
    add(1, LW, 0, 0, 0, '0, en_m, "rl_reset1");
    add(1, LW, 0, 0, 0, '0, en_m, "rl_reset2");
    add(0, RT, 6'b101010, 0, 0, fet0, all_m, "fetch_stall1");
    add(0, RT, 6'b101010, 0, 0, fet0t, all_m, "fetch_stall2_timeout");
    add(0, RT, 6'b101010, 0, 0, fet0, all_m, "fetch_stall3_saturated");
    for (int i = 0; i < 5; i++) begin
      add(0, RT, fs[i], 0, 1, fet1, all_m, $sformatf("rt%0d_fetch", i));
      add(0, RT, fs[i], 0, 1, dec, all_m, $sformatf("rt%0d_decode", i));
      add(0, RT, fs[i], 0, 1, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, cs[i], 0, 0), all_m,
          $sformatf("rt%0d_ex", i));
      add(0, RT, fs[i], 0, 1, awb, ma, $sformatf("rt%0d_wb", i));
    end
    for (int z = 1; z >= 0; z--) begin
      add(0, BEQ, 0, z[0], 1, fet1, all_m, $sformatf("beq_z%0d_fetch", z));
      add(0, BEQ, 0, z[0], 1, dec, all_m, $sformatf("beq_z%0d_decode", z));
      add(0, BEQ, 0, z[0], 1, ov(0, 0, 0, 0, z[0], 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0), all_m,
          $sformatf("beq_z%0d_branch", z));
    end
    add(0, SW, 0, 0, 1, fet1, all_m, "sw_fetch");
    add(0, SW, 0, 0, 1, dec, all_m, "sw_decode");
    add(0, SW, 0, 0, 1, madr, all_m, "sw_memadr");
    add(0, SW, 0, 0, 0, mwr, ma, "sw_stall1");
    add(0, SW, 0, 0, 0, mwrt, ma, "sw_stall2_timeout");
    add(0, SW, 0, 0, 0, mwr, ma, "sw_stall3_saturated");
    add(0, SW, 0, 0, 1, mwr, ma, "sw_done");
    add(0, 6'h3F, 0, 0, 1, fet1, all_m, "badop_fetch");
    add(0, 6'h3F, 0, 0, 1, deci, all_m, "badop_decode");
    add(0, RT, 6'b000000, 0, 1, fet1, all_m, "badfunct_fetch");
    add(0, RT, 6'b000000, 0, 1, dec, all_m, "badfunct_decode");
    add(0, RT, 6'b000000, 0, 1, rti, ma, "badfunct_ex");
    add(0, ADDI, 0, 0, 1, fet1, all_m, "addi_fetch");
    add(0, ADDI, 0, 0, 1, dec, all_m, "addi_decode");
    add(0, ADDI, 0, 0, 1, madr, all_m, "addi_ex");
    add(0, ADDI, 0, 0, 1, awbi, ma, "addi_wb");
    add(0, J, 0, 0, 1, fet1, all_m, "j_fetch");
    add(0, J, 0, 0, 1, dec, all_m, "j_decode");
    add(0, J, 0, 0, 1, jmp, ma, "j_jump");
    add(0, J, 0, 0, 1, fet1, all_m, "end_fetch");
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t s;
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].funct;
      zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      s.exp = vecs[i].exp; s.mask = vecs[i].mask; s.name = vecs[i].name;
      sb.push_back(s);
      @(negedge clk);
      check(act, sb.pop_front());
      @(posedge clk); #1;
    end
    lat(J, 0, 3, "j_latency");
    lat(LW, 0, 5, "lw_latency");
    lat(LW, 2, 7, "lw_stall2_latency");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
